// File: rtl/bcd_code_conv_seq.sv
// ---- bcd_code_conv_seq : multi-digit BCD code converter, one digit per clock, valid/ready I/O ----
// ---- Rev 1.0 : initial release                                                                 ----
`default_nettype none

module bcd_code_conv_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] din,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] dout,
  output logic [DIGITS-1:0]   err,
  output logic                any_err,
  output logic                busy
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [4*DIGITS-1:0] din_q;
  logic [1:0]          mode_q;
  logic [CW-1:0]       cnt;
  logic [3:0]          cur_digit;
  logic [3:0]          cur_code;
  logic                cur_bad;
  logic                last_digit;

  // Returns {invalid, code}; invalid inputs map to code 0000.
  function automatic logic [4:0] conv_digit(input logic [1:0] m, input logic [3:0] d);
    logic [4:0] r;
    r = 5'b1_0000;
    case (m)
      2'd0: begin
        case (d)
          4'd0: r = 5'b0_0000;
          4'd1: r = 5'b0_0111;
          4'd2: r = 5'b0_0110;
          4'd3: r = 5'b0_0101;
          4'd4: r = 5'b0_0100;
          4'd5: r = 5'b0_1011;
          4'd6: r = 5'b0_1010;
          4'd7: r = 5'b0_1001;
          4'd8: r = 5'b0_1000;
          4'd9: r = 5'b0_1111;
          default: r = 5'b1_0000;
        endcase
      end
      2'd1: begin
        case (d)
          4'd0: r = 5'b0_0000;
          4'd1: r = 5'b0_0001;
          4'd2: r = 5'b0_0010;
          4'd3: r = 5'b0_0011;
          4'd4: r = 5'b0_0100;
          4'd5: r = 5'b0_1011;
          4'd6: r = 5'b0_1100;
          4'd7: r = 5'b0_1101;
          4'd8: r = 5'b0_1110;
          4'd9: r = 5'b0_1111;
          default: r = 5'b1_0000;
        endcase
      end
      2'd2: begin
        if (d <= 4'd9) r = {1'b0, d + 4'd3};
        else           r = 5'b1_0000;
      end
      default: begin
        case (d)
          4'b0000: r = 5'b0_0000;
          4'b0111: r = 5'b0_0001;
          4'b0110: r = 5'b0_0010;
          4'b0101: r = 5'b0_0011;
          4'b0100: r = 5'b0_0100;
          4'b1011: r = 5'b0_0101;
          4'b1010: r = 5'b0_0110;
          4'b1001: r = 5'b0_0111;
          4'b1000: r = 5'b0_1000;
          4'b1111: r = 5'b0_1001;
          default: r = 5'b1_0000;
        endcase
      end
    endcase
    return r;
  endfunction

  // Digit select by loop so DIGITS=1 needs no out-of-range part select.
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cnt == CW'(k)) cur_digit = din_q[4*k +: 4];
    end
  end

  always_comb begin
    {cur_bad, cur_code} = conv_digit(mode_q, cur_digit);
  end

  assign last_digit = (cnt == CW'(DIGITS - 1));
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)   state_nx = CONV;
      CONV:    if (last_digit) state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q     <= '0;
      mode_q    <= 2'd0;
      cnt       <= '0;
      dout      <= '0;
      err       <= '0;
      any_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            din_q   <= din;
            mode_q  <= mode;
            dout    <= '0;
            err     <= '0;
            any_err <= 1'b0;
            cnt     <= '0;
          end
        end
        CONV: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (cnt == CW'(k)) begin
              dout[4*k +: 4] <= cur_code;
              err[k]         <= cur_bad;
            end
          end
          if (last_digit) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            // err bit for this digit was cleared at accept, so OR in the fresh flag.
            any_err   <= (|err) | cur_bad;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_code_conv_seq.sv
// ---- tb_bcd_code_conv_seq : vector table, corner sequences and random words vs reference model ----
// ---- Rev 1.0 : initial release                                                                  ----
`default_nettype none

module tb_bcd_code_conv_seq;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] din = '0;
  logic [1:0]   mode = 2'd0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] dout;
  logic [D-1:0] err;
  logic         any_err;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_code_conv_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .err(err), .any_err(any_err), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] T8421 [10] = '{4'h0, 4'h7, 4'h6, 4'h5, 4'h4, 4'hB, 4'hA, 4'h9, 4'h8, 4'hF};
  localparam logic [3:0] T2421 [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  // Decimal meaning of each nibble, then table lookup; mode 3 searches the 84-2-1 table.
  function automatic void ref_conv(input logic [1:0] m, input logic [W-1:0] d,
                                   output logic [W-1:0] r, output logic [D-1:0] e);
    logic [3:0] nib;
    logic [3:0] val;
    logic       ok;
    r = '0;
    e = '0;
    for (int k = 0; k < D; k++) begin
      nib = d[4*k +: 4];
      ok  = 1'b0;
      val = 4'd0;
      if (m == 2'd3) begin
        for (int v = 0; v < 10; v++) begin
          if (T8421[v] == nib) begin
            ok  = 1'b1;
            val = 4'(v);
          end
        end
      end else if (int'(nib) <= 9) begin
        ok = 1'b1;
        if (m == 2'd0)      val = T8421[int'(nib)];
        else if (m == 2'd1) val = T2421[int'(nib)];
        else                val = 4'(int'(nib) + 3);
      end
      r[4*k +: 4] = ok ? val : 4'd0;
      e[k]        = ~ok;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic send_word(input logic [1:0] m, input logic [W-1:0] d,
                           input logic [W-1:0] er, input logic [D-1:0] ee,
                           input int hold, input bit pres);
    int k;
    int cnt;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    mode      = m;
    din       = d;
    in_valid  = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        if (pres) begin
          in_valid = 1'b1;
          din      = 16'h3333;
          mode     = 2'd0;
        end else begin
          in_valid = 1'b0;
          din      = W'($urandom);
          mode     = 2'($urandom);
        end
      end
    end while (!out_valid && cnt < 20);
    chk("latency", 32'(cnt - 1), 32'(D));
    chk("dout", 32'(dout), 32'(er));
    chk("err", 32'(err), 32'(ee));
    chk("any_err", 32'(any_err), 32'(|ee));
    chk("busy_done", 32'(busy), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_dout", 32'(dout), 32'(er));
      chk("hold_err", 32'(err), 32'(ee));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    if (!pres) in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [D-1:0] e;
    int           hold;
  } vec_t;

  initial begin
    vec_t         vt[8];
    logic [W-1:0] rr;
    logic [D-1:0] ee;
    logic [1:0]   mm;
    logic [W-1:0] dd;
    logic [W+D:0] q[$];
    logic [W+D:0] exp_q;
    int           accepts;
    int           last_acc;
    int           cyc;
    bit           newword;

    vt[0] = '{m: 2'd0, d: 16'h1959, r: 16'h7FBF, e: 4'b0000, hold: 0};
    vt[1] = '{m: 2'd1, d: 16'h0789, r: 16'h0DEF, e: 4'b0000, hold: 0};
    vt[2] = '{m: 2'd2, d: 16'h2A05, r: 16'h5038, e: 4'b0100, hold: 0};
    vt[3] = '{m: 2'd3, d: 16'h7FBC, r: 16'h1950, e: 4'b0001, hold: 0};
    vt[4] = '{m: 2'd0, d: 16'h9999, r: 16'hFFFF, e: 4'b0000, hold: 2};
    vt[5] = '{m: 2'd2, d: 16'hFABC, r: 16'h0000, e: 4'b1111, hold: 0};
    vt[6] = '{m: 2'd3, d: 16'h0F12, r: 16'h0900, e: 4'b0011, hold: 1};
    vt[7] = '{m: 2'd1, d: 16'h5600, r: 16'hBC00, e: 4'b0000, hold: 0};

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_any_err", 32'(any_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      send_word(vt[i].m, vt[i].d, vt[i].r, vt[i].e, vt[i].hold, 1'b0);

    // Backpressure with a second word waiting on the input.
    send_word(2'd0, 16'h1959, 16'h7FBF, 4'b0000, 5, 1'b1);
    send_word(2'd0, 16'h3333, 16'h5555, 4'b0000, 0, 1'b0);

    // Reset two cycles into CONV aborts the word.
    mode = 2'd1; din = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_result", 32'(out_valid), 32'd0);
    send_word(2'd0, 16'h0004, 16'h0004, 4'b0000, 0, 1'b0);

    // Random words with random backpressure against the model.
    for (int i = 0; i < 25; i++) begin
      mm = 2'($urandom);
      dd = W'($urandom);
      ref_conv(mm, dd, rr, ee);
      send_word(mm, dd, rr, ee, int'($urandom_range(0, 2)), 1'b0);
    end

    // Back-to-back: in_valid held, new word after each accept.
    out_ready = 1'b1;
    accepts   = 0;
    last_acc  = -1;
    newword   = 1'b1;
    cyc       = 0;
    while ((accepts < 8 || q.size() != 0) && cyc < 120) begin
      if (newword) begin
        newword = 1'b0;
        if (accepts < 8) begin
          din      = W'($urandom);
          mode     = 2'($urandom);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_spurious", 32'(out_valid), 32'd0);
        end else begin
          exp_q = q.pop_front();
          chk("b2b_dout", 32'(dout), 32'(exp_q[W-1:0]));
          chk("b2b_err", 32'(err), 32'(exp_q[W+D-1:W]));
          chk("b2b_any_err", 32'(any_err), 32'(exp_q[W+D]));
        end
      end
      if (in_valid && in_ready) begin
        ref_conv(mode, din, rr, ee);
        q.push_back({|ee, ee, rr});
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(D + 2));
        last_acc = cyc;
        accepts++;
        newword = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(accepts), 32'd8);
    chk("b2b_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_code_conv_seq.md
Name: bcd_code_conv_seq

Overview:
Sequential, parametrised multi-digit BCD code converter. Accepts a DIGITS-wide packed BCD word over a valid/ready handshake. Converts one digit per clock, LSB nibble first, into a runtime-selected target code, then presents the result on a valid/ready output port. It is the multi-digit, multi-code successor to the team's single-digit combinational BCD to 84-2-1 converter, and adds per-digit error flagging.

Parameters:
DIGITS, 4, number of 4-bit digits per word (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word (high only in IDLE)
din  input  4*DIGITS  packed input digits, digit k = din[4k+3:4k]
mode  input  2  0: BCD->84-2-1, 1: BCD->2421, 2: BCD->excess-3, 3: 84-2-1->BCD
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
dout  output  4*DIGITS  converted digits, same packing as din
err  output  DIGITS  per-digit invalid-code flag
any_err  output  1  OR of err, valid with out_valid
busy  output  1  high in CONV or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid=0, dout=0, err=0, any_err=0, busy=0; digit counter=0.
- in_ready = (state==IDLE). It is combinational from state, so it reads 1 while in reset.
- FSM states and transitions:
  - IDLE: on in_valid&&in_ready at edge T, latch din and mode, clear dout/err, counter=0, go to CONV.
  - CONV: each edge converts digit[counter] into dout/err nibble[counter] and increments counter. After digit DIGITS-1 is written (edge T+DIGITS), go to DONE and set out_valid=1.
  - DONE: hold dout, err, any_err and out_valid stable. On out_valid&&out_ready, clear out_valid and go to IDLE. in_ready is high in the following cycle.
- Latency: out_valid rises exactly DIGITS cycles after the accepting edge. Minimum cycles between accepts is DIGITS+2.
- The latched mode is used for the whole word. Changes on the mode/din pins after accept are ignored.
- in_valid during CONV/DONE is ignored, and no word is dropped silently: the producer must hold the word, since in_ready=0.
- Code tables, listing outputs for digits 0..9:
  - 84-2-1: 0000 0111 0110 0101 0100 1011 1010 1001 1000 1111
  - 2421: 0000 0001 0010 0011 0100 1011 1100 1101 1110 1111
  - excess-3: digit+3 (0011..1100)
  - mode 3: inverse of the 84-2-1 table.
- Invalid input handling:
  - Modes 0-2: digit values 1010..1111 are invalid.
  - Mode 3: codes 0001, 0010, 0011, 1100, 1101, 1110 are invalid.
  - An invalid digit outputs nibble 0000 and sets err[k]=1. Other digits convert normally.
- any_err = |err, updated at the DONE transition.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-CONV or mid-DONE aborts the word immediately; no partial result is ever presented.
- DIGITS=1: CONV lasts one cycle, and the counter is a single bit or tied 0.

Test Plan:
1. DIGITS=4, mode=0, din=16'h1959, out_ready=1 -> out_valid exactly 4 cycles after accept; dout=16'h7FBF, err=4'b0000, any_err=0; out_valid high 1 cycle.
2. mode=1, din=16'h0789 -> dout=16'h0DEF, err=0. Then mode=2, din=16'h2A05 -> dout=16'h5038, err=4'b0100, any_err=1.
3. mode=3, din=16'h7FBC -> dout=16'h1950, err=4'b0001, any_err=1.
4. Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and din=16'h3333 presented -> dout/err/out_valid stable, in_ready=0, second word not accepted. Then out_ready=1 -> handshake; in_ready=1 next cycle; second word accepted and converted (mode 0 -> 16'h5555).
5. rst_n pulsed low 2 cycles after accept during CONV -> out_valid=0, dout=0, err=0, busy=0, in_ready=1 immediately. The next word 16'h0004 (mode 0) yields dout=16'h0004, err=0.
6. Back-to-back: in_valid held high with a new word each accept, out_ready=1 -> accepts spaced DIGITS+2 cycles (6 cycles for DIGITS=4), all results correct, no duplicated or lost words.
